instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
Fetch-side initiator for the instruction memory. It holds the program counter, drives the word address, and captures the returned instruction into an IF/ID register. That register is handed to decode over a valid/ready handshake. Jumps (op 000100) are resolved locally, taken beq redirects come from execute, and misaligned or out-of-range fetches force a sticky fault state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_WORDS, 32, instruction memory depth in words; legal PC range 0 .. MEM_WORDS*4-4

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
imem_addr  output  32  byte address to instruction memory; equals pc
imem_ins  input  32  instruction word returned combinationally for imem_addr
id_valid  output  1  IF/ID register holds a valid instruction
id_ready  input  1  decode accepts the IF/ID contents this cycle
id_instr  output  32  registered instruction
id_pc_plus4  output  32  registered PC+4 of id_instr
br_taken  input  1  execute-stage taken-branch redirect, single-cycle pulse
br_target  input  32  redirect byte address, sampled when br_taken=1
fault  output  1  sticky: fetch stopped on misaligned or out-of-range PC
fetch_count  output  32  number of instructions loaded into IF/ID since reset

Behaviour:
- Reset: one clock; rst is asynchronous and active-low. While rst=0: pc=RESET_PC, id_valid=0, id_instr=0, id_pc_plus4=0, fault=0, fetch_count=0, state=RUN. Nothing is registered on the cycle rst deasserts except the state already loaded.
- imem_addr = pc, combinational. Memory read latency is 0; the instruction is captured on the same edge.
- States:
  - RUN: normal fetch.
  - FAULT: pc frozen, id_valid=0, id_ready ignored, br_taken ignored. FAULT is exited only by reset.
- advance = (id_valid==0) | id_ready. This is the IF/ID load enable.
- Priority each rising edge in RUN:
  1. br_taken=1:
     - pc<=br_target and id_valid<=0 (flush), regardless of advance.
     - br_target[1:0]!=0 or br_target>=MEM_WORDS*4: state<=FAULT, fault<=1, pc unchanged.
  2. Else if pc is illegal (pc[1:0]!=0 or pc>=MEM_WORDS*4): state<=FAULT, fault<=1, id_valid<=0. This covers the case where the final pc+4 runs off the end of memory.
  3. Else if advance:
     - id_instr<=imem_ins, id_pc_plus4<=pc+4, id_valid<=1, fetch_count<=fetch_count+1.
     - If imem_ins[31:26]==6'b000100 (jump): pc<={pc_plus4[31:28], imem_ins[25:0], 2'b00}.
     - Otherwise pc<=pc+4.
     - The jump word itself is still delivered to decode.
  4. Else (stall, id_valid=1 & id_ready=0): all registers hold.
- Jump target legality is checked when that target becomes pc (rule 2), not at jump time.
- Simultaneous br_taken and stall: the redirect wins and IF/ID is flushed. The stalled instruction is discarded and not counted again.
- Simultaneous br_taken and jump in the fetch slot: the redirect wins and the jump is discarded.
- Redirect penalty: a redirect at edge N gives the first target instruction id_valid=1 after edge N+1.
- Arithmetic: pc+4 and fetch_count wrap modulo 2^32 with no saturation.
- Asynchronous reset mid-stall or mid-FAULT: immediate return to the reset values.

Test Plan:
- Reset release with memory words 0-12 loaded (word 12 = 32'h1000_0000, j 0), id_ready=1 constant -> imem_addr steps 0,4,…,48,0,4. Each instruction appears on id_instr one cycle after its address. After word 12, the next id_pc_plus4 is 4. fetch_count=13 after the first pass.
- id_ready=0 for 3 cycles at pc=8 -> id_instr holds word 1 and id_pc_plus4 holds 8 for 3 cycles. pc stays 8 and fetch_count does not change. Delivery resumes the cycle after id_ready=1.
- br_taken=1 with br_target=32'h14 while id_valid=1 and stalled -> next cycle id_valid=0, pc=0x14. Next cycle id_instr=word 5, id_pc_plus4=0x18.
- br_taken=1 with br_target=32'h0000_0006 -> fault=1 next edge, id_valid=0, pc frozen. Later br_taken and id_ready are ignored until rst pulses low.
- RESET_PC=120 with MEM_WORDS=32 -> word 31 is fetched at pc=124. The following edge sets fault=1 because pc=128 is out of range.
- Assert rst=0 asynchronously mid-cycle during a stall -> all outputs reach their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: instruction memory port, IF/ID handshake, redirect input and status.
interface instruction_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_ins;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fault;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr, id_valid, id_instr, id_pc_plus4, fault, fetch_count,
    input  imem_ins, id_ready, br_taken, br_target
  );

  modport slave (
    input  imem_addr, id_valid, id_instr, id_pc_plus4, fault, fetch_count,
    output imem_ins, id_ready, br_taken, br_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC, zero-latency memory read into the IF/ID register, local jumps,
// execute redirects and a sticky fault on misaligned or out-of-range fetch addresses.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst,
  instruction_fetch_if.master bus
);

  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [5:0]  OP_JUMP   = 6'b000100;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state_p1, state_d;
  logic [31:0] pc_p0, pc_d;
  logic        vld_p1, vld_d;
  logic [31:0] instr_p1, instr_d;
  logic [31:0] pc_plus4_p1, pc_plus4_d;
  logic [31:0] count_p1, count_d;
  logic [31:0] pc_plus4;
  logic        advance;

  function automatic logic illegal_addr(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= MEM_BYTES);
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] index);
    return {region, index, 2'b00};
  endfunction

  assign pc_plus4 = pc_p0 + 32'd4;
  assign advance  = !vld_p1 || bus.id_ready;

  always_comb begin
    state_d    = state_p1;
    pc_d       = pc_p0;
    vld_d      = vld_p1;
    instr_d    = instr_p1;
    pc_plus4_d = pc_plus4_p1;
    count_d    = count_p1;
    if (state_p1 == RUN) begin
      if (bus.br_taken) begin
        // Redirect wins over stall and over a jump in the fetch slot.
        vld_d = 1'b0;
        if (illegal_addr(bus.br_target)) begin
          state_d = FAULT;
        end else begin
          pc_d = bus.br_target;
        end
      end else if (illegal_addr(pc_p0)) begin
        state_d = FAULT;
        vld_d   = 1'b0;
      end else if (advance) begin
        instr_d    = bus.imem_ins;
        pc_plus4_d = pc_plus4;
        vld_d      = 1'b1;
        count_d    = count_p1 + 32'd1;
        if (bus.imem_ins[31:26] == OP_JUMP) begin
          pc_d = jump_target(pc_plus4[31:28], bus.imem_ins[25:0]);
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  // Stage p1: IF/ID register, PC and fetch state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p1    <= RUN;
      pc_p0       <= RESET_PC;
      vld_p1      <= 1'b0;
      instr_p1    <= 32'd0;
      pc_plus4_p1 <= 32'd0;
      count_p1    <= 32'd0;
    end else begin
      state_p1    <= state_d;
      pc_p0       <= pc_d;
      vld_p1      <= vld_d;
      instr_p1    <= instr_d;
      pc_plus4_p1 <= pc_plus4_d;
      count_p1    <= count_d;
    end
  end

  assign bus.imem_addr   = pc_p0;
  assign bus.id_valid    = vld_p1;
  assign bus.id_instr    = instr_p1;
  assign bus.id_pc_plus4 = pc_plus4_p1;
  assign bus.fault       = (state_p1 == FAULT);
  assign bus.fetch_count = count_p1;

endmodule
